// File: rtl/uart_out_unit.sv
// Output-side responder for the core OUT handshake: buffers the low byte of each
// write in a small FIFO and shifts it out as a UART 8N1 frame on txd.
module uart_out_unit #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AW     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_req,
    input  logic [31:0] out_data,
    output logic        out_busy,
    output logic        txd,
    output logic        tx_active,
    output logic        overflow
);

    localparam int                  BAUD_W     = $clog2(CLK_PER_BIT);
    localparam logic [BAUD_W-1:0]   BAUD_LAST  = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [FIFO_AW:0]    COUNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic [7:0]         fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_d;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               overflow_q;

    state_e             state_q;
    logic [BAUD_W-1:0]  baud_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               txd_q;

    logic               full;
    logic               push;
    logic               pop;
    logic               baud_done;

    // Only the low byte goes on the wire; the upper bits are intentionally ignored.
    logic               unused_data;
    assign unused_data = ^out_data[31:8];

    assign full      = (count_q == COUNT_FULL);
    assign push      = out_req && !full;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= out_data[7:0];
        end
    end

    // The full check uses the pre-edge count, so a push into a full FIFO is dropped
    // even when a pop happens on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (out_req && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    txd_q  <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_mem_q[rd_ptr_q];
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign out_busy  = full;
    assign txd       = txd_q;
    assign tx_active = (state_q != IDLE);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_out_unit.sv
// Directed bench for uart_out_unit: pushes are logged into an expected-byte queue
// and a UART monitor decodes every frame and compares it against that queue.
module tb_uart_out_unit;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        outReq = 1'b0;
    logic [31:0] outData = '0;
    logic        outBusy;
    logic        txd;
    logic        txActive;
    logic        overflow;

    int          assertCount = 0;
    int          failCount = 0;
    int          cycleCnt = 0;
    bit          monEn = 1'b0;
    logic [7:0]  expQ[$];
    int          startTimes[$];

    uart_out_unit #(
        .CLK_PER_BIT(CPB),
        .FIFO_DEPTH (DEPTH),
        .FIFO_AW    (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_req  (outReq),
        .out_data (outData),
        .out_busy (outBusy),
        .txd      (txd),
        .tx_active(txActive),
        .overflow (overflow)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle's request; accepted bytes are logged as expected wire output.
    task automatic applyStimulus(input logic req, input logic [31:0] data, input bit expectTx);
        outReq  = req;
        outData = data;
        if (expectTx) expQ.push_back(data[7:0]);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || txActive !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain within budget", 32'(n < budget), 32'd1);
    endtask

    // UART monitor: samples each bit one cycle into its bit period.
    initial begin
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (monEn && txd === 1'b0) begin
                startTimes.push_back(cycleCnt);
                got = '0;
                for (int k = 0; k < 8; k++) begin
                    repeat ((k == 0) ? CPB + 1 : CPB) @(negedge clk);
                    got[k] = txd;
                end
                repeat (CPB) @(negedge clk);
                checkOutput("stop bit", {31'b0, txd}, 32'd1);
                checkOutput("scoreboard has entry", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) checkOutput("rx byte", {24'b0, got}, {24'b0, expQ.pop_front()});
            end
        end
    end

    initial begin
        logic [9:0] frame;
        int         n;
        int         sent;
        int         guard;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset txd", {31'b0, txd}, 32'd1);
        checkOutput("reset busy", {31'b0, outBusy}, 32'd0);
        checkOutput("reset tx_active", {31'b0, txActive}, 32'd0);
        checkOutput("reset overflow", {31'b0, overflow}, 32'd0);
        rst = 1'b0;

        // Abort a frame in its start bit with reset.
        applyStimulus(1'b1, 32'h0000_0077, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("abort pre-start txd", {31'b0, txd}, 32'd1);
        @(negedge clk);
        checkOutput("abort start low", {31'b0, txd}, 32'd0);
        checkOutput("abort active", {31'b0, txActive}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort txd high", {31'b0, txd}, 32'd1);
        checkOutput("abort active low", {31'b0, txActive}, 32'd0);
        checkOutput("abort busy", {31'b0, outBusy}, 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort fifo empty", {30'b0, txd, txActive}, 32'd2);
        end
        monEn = 1'b1;

        // Single byte, checked bit by bit against the 8N1 frame.
        frame = {1'b1, 8'hA5, 1'b0};
        applyStimulus(1'b1, 32'hDEAD_BEA5, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("latency txd idle", {31'b0, txd}, 32'd1);
        checkOutput("latency active", {31'b0, txActive}, 32'd0);
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            checkOutput("single frame bit", {31'b0, txd}, {31'b0, frame[i / CPB]});
            checkOutput("single active", {31'b0, txActive}, 32'd1);
        end
        @(negedge clk);
        checkOutput("active falls", {31'b0, txActive}, 32'd0);
        checkOutput("idle txd", {31'b0, txd}, 32'd1);
        waitDrain(100);

        // Back-to-back frames.
        startTimes.delete();
        applyStimulus(1'b1, 32'h1234_5655, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 32'hABCD_EF0F, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitDrain(200);
        checkOutput("b2b frame count", 32'(startTimes.size()), 32'd2);
        if (startTimes.size() == 2)
            checkOutput("b2b spacing", 32'(startTimes[1] - startTimes[0]), 32'd41);

        // Fill the FIFO while frame one is on the wire, then overflow it.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b1);
            @(negedge clk);
            if (i < 5) checkOutput("busy before full", {31'b0, outBusy}, 32'd0);
        end
        checkOutput("busy at full", {31'b0, outBusy}, 32'd1);
        checkOutput("no overflow yet", {31'b0, overflow}, 32'd0);
        applyStimulus(1'b1, 32'h0000_0006, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("overflow set", {31'b0, overflow}, 32'd1);
        checkOutput("busy still full", {31'b0, outBusy}, 32'd1);
        n = 0;
        while (outBusy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy release cycles", 32'(n), 32'd37);
        waitDrain(400);
        checkOutput("overflow sticky", {31'b0, overflow}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("overflow cleared", {31'b0, overflow}, 32'd0);

        // Pushes landing on the same edge as an IDLE pop with count 1.
        applyStimulus(1'b1, 32'h0000_00C3, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_003C, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0);
        n = 0;
        while (txActive !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle reached", 32'(n < 100), 32'd1);
        applyStimulus(1'b1, 32'h0000_0096, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("pop with push starts", {30'b0, txd, txActive}, 32'd1);
        checkOutput("pop with push busy", {31'b0, outBusy}, 32'd0);
        waitDrain(300);

        // Core-style producer that only requests when busy is low.
        sent = 0;
        guard = 0;
        while (sent < 40 && guard < 5000) begin
            if (outBusy === 1'b0 && $urandom_range(0, 3) != 0) begin
                applyStimulus(1'b1, $urandom, 1'b1);
                sent++;
            end else begin
                applyStimulus(1'b0, 32'h0, 1'b0);
            end
            @(negedge clk);
            guard++;
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("handshake sent", 32'(sent), 32'd40);
        waitDrain(5000);
        checkOutput("handshake overflow", {31'b0, overflow}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_out_unit.md
# uart_out_unit

- Output-side responder for the core's `out_req`/`out_data`/`out_busy` handshake.
- Accepts one-cycle write requests carrying a 32-bit word, buffers the low byte in a FIFO, and serializes bytes on a UART 8N1 transmit line.
- Drives `out_busy` so the core stalls its OUT instruction in the execute state whenever the buffer cannot take another byte.
- Sits between the core and the board UART pin in the top-level wrapper.

## Interface
Parameters:
- `CLK_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 2.
- `FIFO_DEPTH`, 16: byte entries in the buffer; power of two, ≥ 2.
- `FIFO_AW`, 4: log2(`FIFO_DEPTH`).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `out_req`  in  1  one-cycle write strobe from the core.
- `out_data`  in  32  word from the core; only bits [7:0] are transmitted.
- `out_busy`  out  1  high when the FIFO is full; combinational from the occupancy count.
- `txd`  out  1  UART serial output, registered, idle high.
- `tx_active`  out  1  high while a frame is in START, DATA or STOP.
- `overflow`  out  1  sticky flag: an `out_req` arrived while full; cleared only by reset.

## Operation
- **Reset** (`rst` high at a posedge):
  - FIFO is emptied: read pointer, write pointer and count are 0.
  - FSM goes to IDLE; baud counter and bit index are 0.
  - `txd`=1, `tx_active`=0, `overflow`=0, `out_busy`=0.
  - A reset mid-frame aborts that frame; `txd` is high from the next cycle.
- **FIFO:**
  - Circular buffer with an `FIFO_AW+1`-bit count (0..`FIFO_DEPTH`).
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Push:**
  - On `out_req`=1 with count < `FIFO_DEPTH`, write `out_data[7:0]` at the write pointer and advance it.
  - On `out_req`=1 with count == `FIFO_DEPTH`, drop the data, set `overflow`, and leave the pointers unchanged.
- **Pop:** happens only in IDLE with count > 0. The head byte is loaded into an 8-bit shift register and the read pointer advances.
- **Simultaneous push and pop:** both take effect and the count is unchanged. A push into a full FIFO in the same cycle as a pop is still dropped, because the full check uses the pre-edge count.
- **`out_busy`:**
  - `out_busy` = (count == `FIFO_DEPTH`).
  - The core samples `out_busy` low and issues at most one `out_req` on the following cycle. Only pops can happen in between, so a full check is sufficient.
- **TX FSM**, baud counter counting 0..`CLK_PER_BIT`-1:
  - IDLE: `txd`=1. If count > 0, pop the head byte and go to START.
  - START: `txd`=0 for `CLK_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for `CLK_PER_BIT` cycles, then shift right (LSB first). After bit index 7, go to STOP; otherwise increment the bit index.
  - STOP: `txd`=1 for `CLK_PER_BIT` cycles, then go to IDLE.
- The baud counter reloads to 0 on every state or bit transition.
- `tx_active` = (state != IDLE).

## Timing
- **Push latency:** `out_req` at edge t updates count by edge t. `out_busy` reflects the new count in cycle t+1.
- **Frame start from empty:**
  - IDLE sees count > 0 in cycle t+1 and pops at edge t+1.
  - `txd` falls in cycle t+2 (registered output).
  - `out_req` to start bit is therefore 2 cycles.
- **Frame length:** 10×`CLK_PER_BIT` cycles from start-bit first cycle to stop-bit last cycle.
- **Back-to-back frames:** one IDLE cycle separates stop bit and next start bit, so the period is 10×`CLK_PER_BIT`+1 cycles.
- **Throughput:** one push per cycle max. Data order is strictly FIFO.
- **Full to not-full:** the pop edge clears `out_busy` in the following cycle.

## Test plan
- **Reset values:** assert `rst` 3 cycles.
  - Expect `txd`=1, `out_busy`=0, `tx_active`=0, `overflow`=0.
  - Reassert `rst` mid-START and expect `txd`=1 next cycle with FIFO empty.
- **Single byte:** `CLK_PER_BIT`=4, `out_req` with `out_data`=32'hDEAD_BEA5.
  - Expect `txd` low 2 cycles later for 4 cycles.
  - Then data bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), 4 cycles each.
  - Then stop bit high for 4 cycles; `tx_active` falls.
- **Back-to-back:** push 0x55 and 0x0F on consecutive cycles.
  - Expect two frames in order.
  - The second start bit begins exactly 41 cycles after the first.
- **Full / busy:** `FIFO_DEPTH`=4, push 5 bytes 0x01..0x05 on consecutive cycles while the TX is stalled on frame one.
  - The first pop makes room, so `out_busy` rises only after the 5th push (count 4).
  - A 6th push is dropped: `overflow`=1.
  - Expect bytes 0x01..0x05 on the wire.
- **Simultaneous push/pop:** push at the exact cycle IDLE pops with count 1. Count stays 1 and the order is preserved.
- **Core handshake:** drive a core-style model that waits for `out_busy`=0 before `out_req`. Send 40 random bytes; every byte is received by a UART monitor, in order, with `overflow`=0.
